// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_if
// Description : Control/status bundle between mc_ctrl and the MIPS datapath.
// Revision    : 1.0  initial release
// ============================================================================
interface mc_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       imem_ready;
   logic       dmem_ready;
   logic       imem_req;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_b;
   logic [5:0] alu_ctrl;
   logic       dmem_req;
   logic       dmem_we;
   logic       illegal;
   logic [2:0] state_o;

   modport master (
      input  op, funct, zero, imem_ready, dmem_ready,
      output imem_req, ir_write, pc_write, pc_src, reg_write, reg_dst,
             mem_to_reg, alu_src_b, alu_ctrl, dmem_req, dmem_we, illegal, state_o
   );

   modport slave (
      output op, funct, zero, imem_ready, dmem_ready,
      input  imem_req, ir_write, pc_write, pc_src, reg_write, reg_dst,
             mem_to_reg, alu_src_b, alu_ctrl, dmem_req, dmem_we, illegal, state_o
   );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle Moore sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//               Optional performance counters: define MC_CTRL_PERF_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl #(
   parameter logic [5:0] FUNCT_ADDU = 6'h21,
   parameter logic [5:0] FUNCT_SUBU = 6'h23
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   parameter int unsigned PERF_W = 32
`endif
) (
   input  logic             clock,
   input  logic             reset,
   mc_ctrl_if.master        bus
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] cycle_cnt,
   output logic [PERF_W-1:0] instr_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   supported;

   always_comb begin
      supported = 1'b0;
      case (bus.op)
         OP_RTYPE: begin
            case (bus.funct)
               6'h21, 6'h23, 6'h24, 6'h25, 6'h2a: supported = 1'b1;
               default:                           supported = 1'b0;
            endcase
         end
         OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: supported = 1'b1;
         default:                              supported = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      illegal_d      = illegal_q;
      bus.imem_req   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 2'd0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_b  = 1'b0;
      bus.alu_ctrl   = 6'h00;
      bus.dmem_req   = 1'b0;
      bus.dmem_we    = 1'b0;
      bus.illegal    = illegal_q;
      bus.state_o    = state_q;

      case (state_q)
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            if (bus.op == OP_J) begin
               bus.pc_write = 1'b1;
               bus.pc_src   = 2'd2;
               state_d      = S_FETCH;
            end else if (supported) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            case (bus.op)
               OP_RTYPE: begin
                  bus.alu_ctrl = bus.funct;
                  state_d      = S_WB;
               end
               OP_ADDIU: begin
                  bus.alu_src_b = 1'b1;
                  bus.alu_ctrl  = FUNCT_ADDU;
                  state_d       = S_WB;
               end
               OP_LW, OP_SW: begin
                  bus.alu_src_b = 1'b1;
                  bus.alu_ctrl  = FUNCT_ADDU;
                  state_d       = S_MEM;
               end
               OP_BEQ: begin
                  bus.alu_ctrl = FUNCT_SUBU;
                  bus.pc_write = bus.zero;
                  bus.pc_src   = 2'd1;
                  state_d      = S_FETCH;
               end
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            // Address path stays driven so the memory sees a stable address while stalled.
            bus.alu_src_b = 1'b1;
            bus.alu_ctrl  = FUNCT_ADDU;
            bus.dmem_req  = 1'b1;
            bus.dmem_we   = (bus.op == OP_SW);
            if (bus.dmem_ready) begin
               state_d = (bus.op == OP_LW) ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            bus.reg_write = 1'b1;
            if (bus.op == OP_RTYPE) begin
               bus.reg_dst  = 1'b1;
               bus.alu_ctrl = bus.funct;
            end else begin
               bus.alu_src_b  = 1'b1;
               bus.alu_ctrl   = FUNCT_ADDU;
               bus.mem_to_reg = (bus.op == OP_LW);
            end
            state_d = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (reset) begin
         bus.imem_req   = 1'b0;
         bus.ir_write   = 1'b0;
         bus.pc_write   = 1'b0;
         bus.pc_src     = 2'd0;
         bus.reg_write  = 1'b0;
         bus.reg_dst    = 1'b0;
         bus.mem_to_reg = 1'b0;
         bus.alu_src_b  = 1'b0;
         bus.alu_ctrl   = 6'h00;
         bus.dmem_req   = 1'b0;
         bus.dmem_we    = 1'b0;
         bus.illegal    = 1'b0;
      end
   end

`ifdef MC_CTRL_PERF_CNT_EN
   localparam logic [PERF_W-1:0] CNT_ONE = PERF_W'(1);

   logic retire;
   assign retire = ((state_q == S_DECODE) && (bus.op == OP_J))
                || ((state_q == S_EXEC) && (bus.op == OP_BEQ))
                || ((state_q == S_MEM) && bus.dmem_ready && (bus.op == OP_SW))
                ||  (state_q == S_WB);

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + CNT_ONE;
         if (retire)            instr_cnt <= instr_cnt + CNT_ONE;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed self-checking bench for mc_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests  = 0;
   int   failed = 0;

   always #5 clock = ~clock;

   mc_ctrl_if bus ();

`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
`endif

   mc_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus)
`ifdef MC_CTRL_PERF_CNT_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   // Packed view: imem,irw,pcw,src[2],rw,rd,m2r,srcb,alu[6],dreq,dwe,ill,state[3]
   logic [20:0] obs;
   assign obs = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                 bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_ctrl,
                 bus.dmem_req, bus.dmem_we, bus.illegal, bus.state_o};

   localparam logic [5:0] A = 6'h21;
   localparam logic [5:0] S = 6'h23;

   function automatic logic [20:0] pk(input logic imem, input logic irw, input logic pcw,
                                      input logic [1:0] src, input logic rw, input logic rd,
                                      input logic m2r, input logic sb, input logic [5:0] alu,
                                      input logic dq, input logic dw, input logic ill,
                                      input logic [2:0] st);
      return {imem, irw, pcw, src, rw, rd, m2r, sb, alu, dq, dw, ill, st};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      tick();
      #2;
      tests++;
      if (obs !== 21'h0) begin
         failed++;
         $display("FAIL reset_hold: got %h exp %h", obs, 21'h0);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #2;
         tests++;
         if (obs !== pk(1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
            failed++;
            $display("FAIL reset_fetch c%0d: got %h exp %h", i, obs, pk(1,0,0,0,0,0,0,0,0,0,0,0,0));
         end
         tick();
      end
   endtask

   task automatic test_addu();
      logic [20:0] e [5];
      e[0] = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      e[1] = pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
      e[2] = pk(0,0,0,0,0,0,0,0,A,0,0,0,2);
      e[3] = pk(0,0,0,0,1,1,0,0,A,0,0,0,4);
      e[4] = pk(1,0,0,0,0,0,0,0,0,0,0,0,0);
      bus.op = 6'h00;
      bus.funct = 6'h21;
      bus.dmem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.imem_ready = (i < 4);
         #2;
         tests++;
         if (obs !== e[i]) begin
            failed++;
            $display("FAIL addu c%0d: got %h exp %h", i, obs, e[i]);
         end
         tick();
      end
   endtask

   task automatic test_lw_stall();
      logic [20:0] e [9];
      e[0] = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      e[1] = pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
      e[2] = pk(0,0,0,0,0,0,0,1,A,0,0,0,2);
      for (int k = 3; k < 7; k++) e[k] = pk(0,0,0,0,0,0,0,1,A,1,0,0,3);
      e[7] = pk(0,0,0,0,1,0,1,1,A,0,0,0,4);
      e[8] = pk(1,0,0,0,0,0,0,0,0,0,0,0,0);
      bus.op = 6'h23;
      bus.funct = 6'h00;
      for (int i = 0; i < 9; i++) begin
         bus.imem_ready = (i < 8);
         bus.dmem_ready = (i == 2) || (i == 6) || (i == 7);
         #2;
         tests++;
         if (obs !== e[i]) begin
            failed++;
            $display("FAIL lw_stall c%0d: got %h exp %h", i, obs, e[i]);
         end
         tick();
      end
   endtask

   task automatic test_beq();
      logic [20:0] e [4];
      bus.op = 6'h04;
      bus.funct = 6'h00;
      bus.dmem_ready = 1'b0;
      for (int z = 1; z >= 0; z--) begin
         e[0] = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
         e[1] = pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
         e[2] = pk(0,0,z[0],1,0,0,0,0,S,0,0,0,2);
         e[3] = pk(1,0,0,0,0,0,0,0,0,0,0,0,0);
         bus.zero = z[0];
         for (int i = 0; i < 4; i++) begin
            bus.imem_ready = (i < 3);
            #2;
            tests++;
            if (obs !== e[i]) begin
               failed++;
               $display("FAIL beq z%0d c%0d: got %h exp %h", z, i, obs, e[i]);
            end
            tick();
         end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jump();
      logic [20:0] e [3];
      e[0] = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      e[1] = pk(0,0,1,2,0,0,0,0,0,0,0,0,1);
      e[2] = pk(1,0,0,0,0,0,0,0,0,0,0,0,0);
      bus.op = 6'h02;
      for (int i = 0; i < 3; i++) begin
         bus.imem_ready = (i < 2);
         #2;
         tests++;
         if (obs !== e[i]) begin
            failed++;
            $display("FAIL jump c%0d: got %h exp %h", i, obs, e[i]);
         end
         tick();
      end
   endtask

   task automatic test_trap(input logic [5:0] op, input logic [5:0] funct, input int n_trap);
      bus.op = op;
      bus.funct = funct;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      for (int i = 0; i < n_trap + 2; i++) begin
         logic [20:0] exp;
         exp = (i == 0) ? pk(1,1,1,0,0,0,0,0,0,0,0,0,0) :
               (i == 1) ? pk(0,0,0,0,0,0,0,0,0,0,0,0,1) :
                          pk(0,0,0,0,0,0,0,0,0,0,0,1,7);
         #2;
         tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL trap op%h c%0d: got %h exp %h", op, i, obs, exp);
         end
         tick();
      end
      reset = 1'b1;
      #2;
      tests++;
      if (obs[20:4] !== 17'h0) begin
         failed++;
         $display("FAIL trap_reset_strobes: got %h exp 0", obs[20:4]);
      end
      tick();
      reset = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #2;
      tests++;
      if (obs !== pk(1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
         failed++;
         $display("FAIL trap_exit: got %h exp %h", obs, pk(1,0,0,0,0,0,0,0,0,0,0,0,0));
      end
      tick();
   endtask

   task automatic test_reset_in_mem();
      logic [20:0] e [4];
      e[0] = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      e[1] = pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
      e[2] = pk(0,0,0,0,0,0,0,1,A,0,0,0,2);
      e[3] = pk(0,0,0,0,0,0,0,1,A,1,1,0,3);
      bus.op = 6'h2b;
      bus.dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.imem_ready = (i == 0);
         #2;
         tests++;
         if (obs !== e[i]) begin
            failed++;
            $display("FAIL sw_mem c%0d: got %h exp %h", i, obs, e[i]);
         end
         if (i < 3) tick();
      end
      reset = 1'b1;
      #2;
      tests++;
      if (obs[20:4] !== 17'h0) begin
         failed++;
         $display("FAIL sw_reset_strobes: got %h exp 0", obs[20:4]);
      end
      tick();
      reset = 1'b0;
      #2;
      tests++;
      if (obs !== pk(1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
         failed++;
         $display("FAIL sw_reset_fetch: got %h exp %h", obs, pk(1,0,0,0,0,0,0,0,0,0,0,0,0));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [20:0] e [11];
      logic [5:0]  ops [11];
      e[0]  = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      e[1]  = pk(0,0,1,2,0,0,0,0,0,0,0,0,1);
      e[2]  = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      e[3]  = pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
      e[4]  = pk(0,0,0,0,0,0,0,1,A,0,0,0,2);
      e[5]  = pk(0,0,0,0,1,0,0,1,A,0,0,0,4);
      e[6]  = pk(1,1,1,0,0,0,0,0,0,0,0,0,0);
      e[7]  = pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
      e[8]  = pk(0,0,0,0,0,0,0,1,A,0,0,0,2);
      e[9]  = pk(0,0,0,0,0,0,0,1,A,1,1,0,3);
      e[10] = pk(1,0,0,0,0,0,0,0,0,0,0,0,0);
      for (int k = 0; k < 11; k++) ops[k] = (k < 2) ? 6'h02 : (k < 6) ? 6'h09 : 6'h2b;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.dmem_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         bus.op = ops[i];
         bus.imem_ready = (i < 10);
         #2;
         tests++;
         if (obs !== e[i]) begin
            failed++;
            $display("FAIL b2b c%0d: got %h exp %h", i, obs, e[i]);
         end
`ifdef MC_CTRL_PERF_CNT_EN
         if (i == 10) begin
            tests++;
            if (instr_cnt !== 32'd3) begin
               failed++;
               $display("FAIL instr_cnt: got %0d exp 3", instr_cnt);
            end
            tests++;
            if (cycle_cnt !== 32'd10) begin
               failed++;
               $display("FAIL cycle_cnt: got %0d exp 10", cycle_cnt);
            end
         end
`endif
         tick();
      end
      bus.dmem_ready = 1'b0;
   endtask

   initial begin
      bus.op = 6'h00;
      bus.funct = 6'h00;
      bus.zero = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #1;
      test_reset();
      test_addu();
      test_lw_stall();
      test_beq();
      test_jump();
      test_trap(6'h3f, 6'h00, 10);
      test_trap(6'h00, 6'h20, 2);
      test_reset_in_mem();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
